bcd_complement_seq: RTL and testbench
=====================================

Name: bcd_complement_seq

Overview:
- Parametrised, digit-serial complement unit: 1's, 9's, 2's or 10's complement of a DIGITS-nibble operand, selected per transaction.
- Processes one 4-bit nibble per clock, LSB nibble first, with a ripple carry between nibbles.
- Valid/ready handshake on input and output, so it can sit between pipeline stages in the arithmetic datapath (e.g. ahead of a BCD subtractor).
- Flags non-BCD digits in decimal modes.

Parameters:
- DIGITS, 4, number of 4-bit nibbles in the operand; legal range 1..16; operand width W = 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand and mode are valid.
- in_ready  output  1  block can accept an operand; high only in IDLE.
- in_data  input  W  operand; nibble i = in_data[4i+3:4i].
- in_mode  input  2  bit0: 1 = decimal (9's/10's), 0 = binary (1's/2's); bit1: 1 = add one (2's/10's). Encoding: 00 = 1's, 01 = 9's, 10 = 2's, 11 = 10's.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts the result.
- out_data  output  W  complemented result.
- out_cout  output  1  carry out of the most significant nibble.
- out_err  output  1  at least one nibble was greater than 9 in a decimal mode.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - State goes to IDLE.
  - out_valid = 0, out_data = 0, out_cout = 0, out_err = 0, busy = 0, in_ready = 1 in the following cycle.
  - Reset mid-RUN or mid-DONE aborts the transaction; no result is emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_data and in_mode, set carry = in_mode[1], clear err, set digit index = 0, go to RUN.
- RUN, one nibble per cycle:
  - Let d = the current nibble, w = ~d (4-bit), c = current carry.
  - Binary mode:
    - r = (w + c) mod 16.
    - carry_next = 1 when w = 0xF and c = 1.
  - Decimal mode, d <= 9:
    - t = (w + 0xA) mod 16, which equals 9 - d.
    - r = t + c.
    - If r = 10: digit = 0, carry_next = 1. Otherwise digit = r, carry_next = 0.
  - Decimal mode, d > 9:
    - digit = (w + 0xA + c) mod 16, carry_next = 0.
    - err is set and stays set (sticky) for the rest of the transaction.
  - The result nibble is written to result[4i+3:4i] and the index increments.
  - When index = DIGITS-1 is processed: go to DONE; out_cout = final carry_next.
- Latency: out_valid is high exactly DIGITS cycles after the accepting edge.
- DONE:
  - out_valid = 1; out_data, out_cout and out_err are held stable while out_ready = 0.
  - On out_ready = 1: go to IDLE, out_valid = 0 next cycle.
  - No new input is accepted in the same cycle as the output handshake; in_ready rises the cycle after.
- out_data, out_cout and out_err keep their last values in IDLE. Only out_valid qualifies them.
- 1's and 9's modes always give out_cout = 0, because the initial carry is 0 and no carry is generated in those modes.
- Zero operand in 2's or 10's mode gives result 0 with out_cout = 1. Non-zero operands give out_cout = 0.
- in_data and in_mode changing during RUN or DONE have no effect.
- DIGITS = 1: RUN lasts one cycle; all rules above still hold.

Test Plan (DIGITS = 4 unless noted):
- Mode 00, in_data = 0x1234 -> out_data = 0xEDCB, out_cout = 0, out_err = 0; out_valid rises 4 cycles after accept.
- Mode 01, 0x1234 -> 0x8765. Mode 11, 0x1234 -> 0x8766, cout = 0. Mode 11, 0x0990 -> 0x9010.
- Mode 11, 0x0000 -> 0x0000, cout = 1. Mode 10, 0x0000 -> 0x0000, cout = 1. Mode 10, 0x0001 -> 0xFFFF, cout = 0.
- Mode 01, 0x12A4 -> out_data = 0x87F5, out_err = 1. A following transaction in mode 01 with 0x0000 -> 0x9999, out_err = 0, confirming err clears per transaction.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready = 0. Drive in_valid with 0x5555 during the stall -> not accepted. Release out_ready -> in_ready = 1 the next cycle.
- Reset mid-RUN: drop rst_n for 1 cycle after 2 nibbles -> IDLE, out_valid never asserted, all outputs 0. Then a fresh mode 11 transaction on 0x0001 -> 0x9999.

Source files
------------

// File: rtl/bcd_complement_seq.sv
// Digit-serial 1's / 9's / 2's / 10's complement of a DIGITS-nibble operand.
// One nibble per clock, LSB first, with a ripple carry between nibbles.
module bcd_complement_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  out_cout,
  output logic                  out_err,
  output logic                  busy
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [W-1:0]       r_opnd, r_acc, r_out_data;
  logic [IDX_W-1:0]   r_idx;
  logic               r_dec, r_carry, r_err, r_out_cout, r_out_err;

  logic [3:0]         w_nib, w_inv, w_t, w_digit;
  logic [4:0]         w_sum;
  logic               w_carry_next, w_bad, w_last;
  logic [W-1:0]       w_acc_next;

  assign w_last = (r_idx == IDX_W'(DIGITS - 1));

  // Per-nibble complement; decimal mode adds 0xA to ~d to get 9-d.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    w_nib        = r_opnd[4*r_idx +: 4];
    w_inv        = ~w_nib;
    w_t          = w_inv + 4'hA;
    w_sum        = {1'b0, w_t} + {4'b0, r_carry};
    w_digit      = '0;
    w_carry_next = 1'b0;
    w_bad        = 1'b0;
    if (!r_dec) begin
      {w_carry_next, w_digit} = {1'b0, w_inv} + {4'b0, r_carry};
    end else if (w_nib <= 4'd9) begin
      if (w_sum == 5'd10) begin
        w_digit      = 4'd0;
        w_carry_next = 1'b1;
      end else begin
        w_digit      = w_sum[3:0];
      end
    end else begin
      w_digit = w_sum[3:0];
      w_bad   = 1'b1;
    end
    w_acc_next                = r_acc;
    w_acc_next[4*r_idx +: 4]  = w_digit;
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state == S_RUN) || (r_state == S_DONE);
  end

  // Datapath: capture, per-nibble update, and result registers held through IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opnd     <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_dec      <= 1'b0;
      r_carry    <= 1'b0;
      r_err      <= 1'b0;
      r_out_data <= '0;
      r_out_cout <= 1'b0;
      r_out_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_opnd  <= in_data;
          r_dec   <= in_mode[0];
          r_carry <= in_mode[1];
          r_err   <= 1'b0;
          r_idx   <= '0;
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_carry_next;
          r_err   <= r_err | w_bad;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_out_data <= w_acc_next;
            r_out_cout <= w_carry_next;
            r_out_err  <= r_err | w_bad;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_out_data;
  assign out_cout = r_out_cout;
  assign out_err  = r_out_err;

endmodule

// File: tb/tb_bcd_complement_seq.sv
// Randomized self-checking bench for bcd_complement_seq against a digit-level
// arithmetic reference model, plus directed corner cases.
module tb_bcd_complement_seq;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [1:0]    in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_cout;
  logic          out_err;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_complement_seq #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cout(out_cout), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: binary modes as whole-word arithmetic, decimal modes digit by digit.
  function automatic void model(input logic [W-1:0] x, input logic [1:0] m,
                                output logic [W-1:0] r, output logic co, output logic er);
    logic [W:0] s;
    int c, d, v;
    r  = '0;
    co = 1'b0;
    er = 1'b0;
    if (!m[0]) begin
      s  = {1'b0, ~x} + (W+1)'(m[1]);
      r  = s[W-1:0];
      co = s[W];
    end else begin
      c = int'(m[1]);
      for (int i = 0; i < DIGITS; i++) begin
        d = int'(x[4*i +: 4]);
        if (d <= 9) begin
          v = 9 - d + c;
          if (v == 10) begin v = 0; c = 1; end
          else c = 0;
        end else begin
          v  = (25 - d + c) % 16;
          c  = 0;
          er = 1'b1;
        end
        r[4*i +: 4] = 4'(v);
      end
      co = (c != 0);
    end
  endfunction

  task automatic run_txn(input logic [W-1:0] x, input logic [1:0] m,
                         input int stall, input bit poke);
    logic [W-1:0] er;
    logic ec, ee;
    int lat;
    model(x, m, er, ec, ee);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = x;
    in_mode  = m;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_mode  = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, DIGITS);
    check("out_data", out_data, er);
    check("out_cout", out_cout, ec);
    check("out_err", out_err, ee);
    check("busy_done", busy, 1);
    for (int k = 0; k < stall; k++) begin
      if (poke) begin
        in_valid = 1'b1;
        in_data  = 16'h5555;
        in_mode  = 2'b00;
      end
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, er);
      check("stall_flags", {out_cout, out_err}, {ec, ee});
      check("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_hold", {out_data, out_cout, out_err}, {er, ec, ee});
  endtask

  initial begin
    logic [W-1:0] x;
    logic [1:0]   m;
    bit           seen;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_outputs", {out_valid, out_data, out_cout, out_err, busy}, '0);
    check("rst_in_ready", in_ready, 1);

    run_txn(16'h1234, 2'b00, 0, 0);
    run_txn(16'h1234, 2'b01, 0, 0);
    run_txn(16'h1234, 2'b11, 1, 0);
    run_txn(16'h0990, 2'b11, 0, 0);
    run_txn(16'h0000, 2'b11, 0, 0);
    run_txn(16'h0000, 2'b10, 0, 0);
    run_txn(16'h0001, 2'b10, 0, 0);
    run_txn(16'h12A4, 2'b01, 0, 0);
    run_txn(16'h0000, 2'b01, 0, 0);
    run_txn(16'h9999, 2'b11, 5, 1);

    // Abort after two nibbles: no result may appear and outputs clear.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h4321;
    in_mode  = 2'b11;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_outputs", {out_valid, out_data, out_cout, out_err, busy}, '0);
    check("abort_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("abort_no_valid", seen, 0);
    run_txn(16'h0001, 2'b11, 0, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       x = '0;
        1: begin
          for (int i = 0; i < DIGITS; i++) x[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        default: x = W'($urandom);
      endcase
      m = 2'($urandom);
      run_txn(x, m, $urandom_range(0, 2), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
